// File: rtl/cpack_length_controller.sv
// C-Pack length controller: per-pair code lengths, accumulator fill tracking and packer strobes per 64-byte line.
// Latency: lengths/store strobes 1 cycle after accept; push/fill in FLUSH cycle, output_flag in DONE cycle.
// Backpressure: o_ready drops for the FLUSH and DONE cycles only. Optional CPACK_STATS_EN adds line counters.
module cpack_length_controller #(
    parameter int CACHE_LINE     = 64,
    parameter int WORDS_PER_LINE = 16,
    parameter int TOTAL_WIDTH    = 136,
    parameter int STORE_CHUNK    = 64,
    parameter int TOTAL_LENGTH   = 7,
    parameter int WORD2_LENGTH   = 6,
    parameter int OUT_SHIFT_BIT  = 7,
    parameter int SIZE_WIDTH     = 10
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_first,
    input  logic [2:0]               i_code1,
    input  logic [2:0]               i_code2,
    output logic                     o_ready,
    output logic [WORD2_LENGTH-1:0]  o_word2_length,
    output logic [TOTAL_LENGTH-1:0]  o_total_length,
    output logic [OUT_SHIFT_BIT-1:0] o_out_shift,
    output logic                     o_store_flag,
    output logic                     o_push_flag,
    output logic                     o_fill_flag,
    output logic                     o_output_flag,
    output logic                     o_stop_flag,
`ifdef CPACK_STATS_EN
    output logic [15:0]              o_lines_done,
    output logic [15:0]              o_lines_stopped,
`endif
    output logic [SIZE_WIDTH-1:0]    o_comp_size
);

    localparam int PAIRS = WORDS_PER_LINE / 2;
    localparam int CNT_W = $clog2(PAIRS + 1);
    localparam int PW    = $clog2(TOTAL_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PW:0]           P_MAX       = (PW+1)'(TOTAL_WIDTH - 1);
    localparam logic [PW-1:0]         CHUNK       = PW'(STORE_CHUNK);
    localparam logic [SIZE_WIDTH:0]   SIZE_MAX    = (SIZE_WIDTH+1)'((1 << SIZE_WIDTH) - 1);
    localparam logic [SIZE_WIDTH-1:0] UNCOMP_BITS = SIZE_WIDTH'(CACHE_LINE * 8);
    localparam logic [SIZE_WIDTH-1:0] FILL_MASK   = SIZE_WIDTH'(STORE_CHUNK * 2 - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT    = CNT_W'(PAIRS);

    function automatic logic [5:0] code_len(input logic [2:0] code);
        case (code)
            3'd0:    code_len = 6'd2;
            3'd2:    code_len = 6'd6;
            3'd3:    code_len = 6'd24;
            3'd4:    code_len = 6'd12;
            3'd5:    code_len = 6'd16;
            default: code_len = 6'd34;  // xxxx and the reserved codes carry a raw word
        endcase
    endfunction

    logic [1:0]              state;
    logic [PW-1:0]           pend;
    logic [CNT_W-1:0]        pair_cnt;

    logic                    accept, restart;
    logic [WORD2_LENGTH-1:0] len1, len2;
    logic [TOTAL_LENGTH-1:0] sum;
    logic [PW-1:0]           base_pend, pnew, pend_next, shift_full;
    logic [PW:0]             pnew_raw;
    logic [SIZE_WIDTH-1:0]   base_size, size_new;
    logic [SIZE_WIDTH:0]     size_raw;
    logic                    base_stop, stop_new, do_store, last_pair;
    logic [CNT_W-1:0]        cnt_new;

    assign o_ready = (state == S_IDLE) || (state == S_ACCUM);

    always_comb begin
        accept     = i_valid && (((state == S_IDLE) && i_first) || (state == S_ACCUM));
        restart    = i_first;
        base_pend  = restart ? '0 : pend;
        base_size  = restart ? '0 : o_comp_size;
        base_stop  = restart ? 1'b0 : o_stop_flag;
        cnt_new    = (restart ? '0 : pair_cnt) + 1'b1;
        last_pair  = (cnt_new == LAST_CNT);
        len1       = WORD2_LENGTH'(code_len(i_code1));
        len2       = WORD2_LENGTH'(code_len(i_code2));
        sum        = TOTAL_LENGTH'(len1) + TOTAL_LENGTH'(len2);
        pnew_raw   = (PW+1)'(base_pend) + (PW+1)'(sum);
        pnew       = (pnew_raw > P_MAX) ? P_MAX[PW-1:0] : pnew_raw[PW-1:0];
        size_raw   = (SIZE_WIDTH+1)'(base_size) + (SIZE_WIDTH+1)'(sum);
        size_new   = (size_raw > SIZE_MAX) ? SIZE_MAX[SIZE_WIDTH-1:0] : size_raw[SIZE_WIDTH-1:0];
        stop_new   = base_stop || (size_new > UNCOMP_BITS);
        do_store   = (pnew >= CHUNK);
        // Fill level keeps tracking after stop so the size stays meaningful.
        pend_next  = do_store ? (pnew - CHUNK) : pnew;
        shift_full = PW'(TOTAL_WIDTH) - pnew;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= S_IDLE;
            pend            <= '0;
            pair_cnt        <= '0;
            o_word2_length  <= '0;
            o_total_length  <= '0;
            o_out_shift     <= '0;
            o_store_flag    <= 1'b0;
            o_push_flag     <= 1'b0;
            o_fill_flag     <= 1'b0;
            o_output_flag   <= 1'b0;
            o_stop_flag     <= 1'b0;
            o_comp_size     <= '0;
`ifdef CPACK_STATS_EN
            o_lines_done    <= '0;
            o_lines_stopped <= '0;
`endif
        end else begin
            o_store_flag  <= 1'b0;
            o_push_flag   <= 1'b0;
            o_fill_flag   <= 1'b0;
            o_output_flag <= 1'b0;
            o_out_shift   <= '0;
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        o_word2_length <= len1;
                        o_total_length <= sum;
                        pend           <= pend_next;
                        o_comp_size    <= size_new;
                        o_stop_flag    <= stop_new;
                        pair_cnt       <= cnt_new;
                        o_store_flag   <= do_store && !stop_new;
                        if (do_store && !stop_new)
                            o_out_shift <= shift_full[OUT_SHIFT_BIT-1:0];
                        if (last_pair) begin
                            // Push/fill land in the FLUSH cycle alongside the last pair's strobes.
                            state       <= S_FLUSH;
                            o_push_flag <= (pend_next != '0) && !stop_new;
                            o_fill_flag <= ((size_new & FILL_MASK) != '0) && !stop_new;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_FLUSH: begin
                    state         <= S_DONE;
                    o_output_flag <= 1'b1;
`ifdef CPACK_STATS_EN
                    o_lines_done  <= o_lines_done + 16'd1;
                    if (o_stop_flag)
                        o_lines_stopped <= o_lines_stopped + 16'd1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
